// File: rtl/otile_transpose_buf.sv
// otile_transpose_buf: ping-pong row collector for the MAC array output.
// Each bank gathers N segments per row, then drains as column-packed words
// to output memory over a valid/ready handshake.
module otile_transpose_buf #(
   parameter int unsigned N  = 4,
   parameter int unsigned DW = 16,
   parameter int unsigned AW = 4
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   CLR,
   input  logic [$clog2(N+1)-1:0] COL_TOTAL,
   input  logic [N*DW-1:0]        MAC_ODATA,
   input  logic [N-1:0]           MAC_OVALID,
   input  logic                   LOAD_EN,
   input  logic [$clog2(N)-1:0]   LOAD_COL,
   input  logic [AW-1:0]          LOAD_ADDR,
   output logic                   IN_STALL,
   output logic                   OM_VALID,
   input  logic                   OM_READY,
   output logic [AW-1:0]          OM_ADDR,
   output logic [N*DW-1:0]        OM_WDATA,
   output logic                   TILE_DONE,
   output logic                   OVF
);

   localparam int unsigned CW = $clog2(N+1);
   localparam int unsigned IW = $clog2(N);
   localparam int unsigned RW = N*DW;

   typedef enum logic {IDLE, WRITE} state_t;

   // bank storage
   logic [RW-1:0] rows_q [2][N];
   logic [RW-1:0] rows_n [2][N];
   logic [CW-1:0] cnt_q  [2][N];
   logic [CW-1:0] cnt_n  [2][N];
   logic [AW-1:0] snap_q [2][N];
   logic [AW-1:0] snap_n [2][N];
   logic [AW-1:0] live_q [N];
   logic [AW-1:0] live_n [N];
   logic [1:0]    full_q, full_n;
   logic          fp_q, fp_n, fb, all_n;
   logic          ovf_n, stall_n;
   logic [1:0]    free;

   // drain control
   state_t        state_q, state_n;
   logic          dp_q, dp_n;
   logic [IW-1:0] c_q, c_n;
   logic [CW-1:0] ct_q, ct_n;
   logic          hs, last_col;
   logic          valid_n, done_n;
   logic [AW-1:0] addr_n;
   logic [RW-1:0] wdata_n;

   // Drain next-state: walk columns 0..CT-1 of bank DP, free it on the last handshake
   always_comb begin
      state_n  = state_q;
      c_n      = c_q;
      ct_n     = ct_q;
      dp_n     = dp_q;
      valid_n  = 1'b0;
      done_n   = 1'b0;
      free     = '0;
      hs       = OM_VALID && OM_READY;
      last_col = (CW'(c_q) == (ct_q - CW'(1)));
      case (state_q)
         IDLE: begin
            if (full_q[dp_q]) begin
               ct_n    = (COL_TOTAL == '0) ? CW'(N) : COL_TOTAL;
               c_n     = '0;
               valid_n = 1'b1;
               state_n = WRITE;
            end
         end
         WRITE: begin
            if (hs && last_col) begin
               done_n     = 1'b1;
               free[dp_q] = 1'b1;
               dp_n       = !dp_q;
               state_n    = IDLE;
            end else begin
               valid_n = 1'b1;
               if (hs) c_n = c_q + IW'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Next output word: column c_n of bank DP, row 0 in the top segment
   always_comb begin
      addr_n  = '0;
      wdata_n = '0;
      if (valid_n) begin
         addr_n = snap_q[dp_q][c_n];
         for (int i = 0; i < N; i++)
            wdata_n[(N-1-i)*DW +: DW] = rows_q[dp_q][i][(N-1-int'(c_n))*DW +: DW];
      end
   end

   // Fill next-state: free drained bank first, then shift in segments and detect completion
   always_comb begin
      rows_n = rows_q;
      cnt_n  = cnt_q;
      snap_n = snap_q;
      live_n = live_q;
      full_n = full_q;
      ovf_n  = OVF;
      all_n  = 1'b1;
      fb     = full_q[fp_q] ? !fp_q : fp_q;
      if (LOAD_EN) live_n[LOAD_COL] = LOAD_ADDR;
      for (int b = 0; b < 2; b++) begin
         if (free[b]) begin
            full_n[b] = 1'b0;
            for (int i = 0; i < N; i++) begin
               rows_n[b][i] = '0;
               cnt_n[b][i]  = '0;
            end
         end
      end
      for (int i = 0; i < N; i++) begin
         if (MAC_OVALID[i]) begin
            if (!full_n[fb] && (cnt_n[fb][i] < CW'(N))) begin
               rows_n[fb][i] = {rows_n[fb][i][RW-DW-1:0], MAC_ODATA[(N-1-i)*DW +: DW]};
               cnt_n[fb][i]  = cnt_n[fb][i] + CW'(1);
            end else begin
               ovf_n = 1'b1;
            end
         end
      end
      for (int i = 0; i < N; i++)
         if (cnt_n[fb][i] != CW'(N)) all_n = 1'b0;
      if (!full_n[fb] && all_n) begin
         full_n[fb] = 1'b1;
         snap_n[fb] = live_n;
      end
      // move to the other bank once this one is full and the other is free
      fp_n    = (full_n[fb] && !full_n[!fb]) ? !fb : fb;
      stall_n = &full_n;
   end

   // Bank registers, fill pointer, stall flag and sticky overflow
   always_ff @(posedge CLK) begin
      if (RST || CLR) begin
         for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < N; i++) begin
               rows_q[b][i] <= '0;
               cnt_q[b][i]  <= '0;
               snap_q[b][i] <= '0;
            end
         end
         for (int i = 0; i < N; i++) live_q[i] <= '0;
         full_q   <= '0;
         fp_q     <= 1'b0;
         IN_STALL <= 1'b0;
      end else begin
         rows_q   <= rows_n;
         cnt_q    <= cnt_n;
         snap_q   <= snap_n;
         live_q   <= live_n;
         full_q   <= full_n;
         fp_q     <= fp_n;
         IN_STALL <= stall_n;
      end
      if (RST)       OVF <= 1'b0;
      else if (!CLR) OVF <= ovf_n;
   end

   // Drain state register and registered write-port outputs
   always_ff @(posedge CLK) begin
      if (RST || CLR) begin
         state_q   <= IDLE;
         dp_q      <= 1'b0;
         c_q       <= '0;
         ct_q      <= '0;
         OM_VALID  <= 1'b0;
         OM_ADDR   <= '0;
         OM_WDATA  <= '0;
         TILE_DONE <= 1'b0;
      end else begin
         state_q   <= state_n;
         dp_q      <= dp_n;
         c_q       <= c_n;
         ct_q      <= ct_n;
         OM_VALID  <= valid_n;
         OM_ADDR   <= addr_n;
         OM_WDATA  <= wdata_n;
         TILE_DONE <= done_n;
      end
   end

endmodule

// File: tb/tb_otile_transpose_buf.sv
// Bench for otile_transpose_buf: tile-level reference model plus directed tests.
module tb_otile_transpose_buf;

   localparam int unsigned N  = 4;
   localparam int unsigned DW = 16;
   localparam int unsigned AW = 4;
   localparam int unsigned CW = $clog2(N+1);
   localparam int unsigned IW = $clog2(N);

   logic            clk = 1'b0;
   logic            rst, clr, load_en, om_ready;
   logic [CW-1:0]   col_total;
   logic [N*DW-1:0] mac_odata;
   logic [N-1:0]    mac_ovalid;
   logic [IW-1:0]   load_col;
   logic [AW-1:0]   load_addr;
   logic            in_stall, om_valid, tile_done, ovf;
   logic [AW-1:0]   om_addr;
   logic [N*DW-1:0] om_wdata;

   always #5 clk = ~clk;

   otile_transpose_buf #(.N(N), .DW(DW), .AW(AW)) dut (
      .CLK(clk), .RST(rst), .CLR(clr), .COL_TOTAL(col_total),
      .MAC_ODATA(mac_odata), .MAC_OVALID(mac_ovalid),
      .LOAD_EN(load_en), .LOAD_COL(load_col), .LOAD_ADDR(load_addr),
      .IN_STALL(in_stall), .OM_VALID(om_valid), .OM_READY(om_ready),
      .OM_ADDR(om_addr), .OM_WDATA(om_wdata), .TILE_DONE(tile_done), .OVF(ovf)
   );

   typedef struct packed {
      logic [AW-1:0]   addr;
      logic [N*DW-1:0] data;
      logic            last;
   } wr_t;

   int tests = 0;
   int fails = 0;
   int done_cnt = 0;
   bit chk_en = 0;

   // reference model: current partial tile, completed tiles, expected writes
   logic [DW-1:0]   m_seg [N][N];
   int              m_cnt [N];
   logic [AW-1:0]   m_tab [N];
   int              m_out;
   wr_t             m_q [$];
   bit              m_ovf, m_done, m_hold;
   logic [AW-1:0]   log_a [$];
   logic [N*DW-1:0] log_d [$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] seg(input int t, input int r, input int c);
      return DW'((t << 12) | (r << 8) | (c << 4));
   endfunction

   task automatic model_clear();
      for (int i = 0; i < N; i++) begin
         m_cnt[i] = 0;
         m_tab[i] = '0;
      end
      m_out  = 0;
      m_q.delete();
      m_done = 0;
      m_hold = 0;
   endtask

   task automatic model_step();
      logic hs;
      bit all;
      int ct;
      wr_t w;
      hs = om_valid && om_ready;
      if (rst) begin
         m_ovf = 0;
         model_clear();
      end else if (clr) begin
         model_clear();
      end else begin
         m_done = 0;
         m_hold = om_valid && !om_ready;
         if (load_en) m_tab[load_col] = load_addr;
         if (hs) begin
            log_a.push_back(om_addr);
            log_d.push_back(om_wdata);
            if (m_q.size() > 0) begin
               w = m_q.pop_front();
               if (w.last) begin
                  m_out--;
                  m_done = 1;
               end
            end
         end
         for (int i = 0; i < N; i++) begin
            if (mac_ovalid[i]) begin
               if (m_out < 2 && m_cnt[i] < int'(N)) begin
                  m_seg[i][m_cnt[i]] = mac_odata[(N-1-i)*DW +: DW];
                  m_cnt[i]++;
               end else begin
                  m_ovf = 1;
               end
            end
         end
         all = 1;
         for (int i = 0; i < N; i++) if (m_cnt[i] != int'(N)) all = 0;
         if (all) begin
            ct = (col_total == '0) ? int'(N) : int'(col_total);
            for (int c = 0; c < ct; c++) begin
               w.addr = m_tab[c];
               w.last = (c == ct - 1);
               for (int r = 0; r < N; r++) w.data[(N-1-r)*DW +: DW] = m_seg[r][c];
               m_q.push_back(w);
            end
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
            m_out++;
         end
      end
   endtask

   // model advances on every rising edge using pre-edge values
   initial forever begin
      @(posedge clk);
      model_step();
   end

   // compare DUT against the model on every falling edge
   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         chk("tile_done", 64'(tile_done), 64'(m_done));
         chk("ovf", 64'(ovf), 64'(m_ovf));
         chk("in_stall", 64'(in_stall), 64'(m_out == 2));
         if (m_hold) chk("hold_valid", 64'(om_valid), 64'(1));
         if (m_q.size() == 0) begin
            chk("idle_valid", 64'(om_valid), 64'(0));
         end else if (om_valid) begin
            chk("om_addr", 64'(om_addr), 64'(m_q[0].addr));
            chk("om_wdata", 64'(om_wdata), 64'(m_q[0].data));
         end
         if (tile_done) done_cnt++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic load_addrs(input int base);
      for (int c = 0; c < N; c++) begin
         @(negedge clk);
         load_en = 1'b1; load_col = IW'(c); load_addr = AW'(base + c);
      end
      @(negedge clk);
      load_en = 1'b0;
   endtask

   task automatic send_tile(input int t, input int skew);
      int span;
      span = int'(N) + skew * (int'(N) - 1);
      for (int s = 0; s < span; s++) begin
         @(negedge clk);
         mac_ovalid = '0;
         mac_odata  = '0;
         for (int r = 0; r < N; r++) begin
            int b;
            b = s - r * skew;
            if (b >= 0 && b < int'(N)) begin
               mac_ovalid[r] = 1'b1;
               mac_odata[(N-1-r)*DW +: DW] = seg(t, r, b);
            end
         end
      end
      @(negedge clk);
      mac_ovalid = '0;
      mac_odata  = '0;
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 200 && (m_q.size() != 0 || m_out != 0); k++) @(negedge clk);
      chk("drain_timeout", 64'(m_q.size() + m_out), 64'(0));
      repeat (2) @(negedge clk);
   endtask

   task automatic wait_log(input int n);
      for (int k = 0; k < 200 && log_a.size() < n; k++) @(negedge clk);
      chk("log_timeout", 64'(log_a.size() >= n), 64'(1));
   endtask

   task automatic start_test();
      log_a.delete();
      log_d.delete();
      done_cnt = 0;
   endtask

   initial begin
      rst = 1'b1; clr = 1'b0; load_en = 1'b0; load_col = '0; load_addr = '0;
      om_ready = 1'b1; col_total = CW'(4); mac_odata = '0; mac_ovalid = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk_en = 1;
      chk("rst_valid", 64'(om_valid), 64'(0));
      chk("rst_done", 64'(tile_done), 64'(0));
      chk("rst_ovf", 64'(ovf), 64'(0));
      chk("rst_stall", 64'(in_stall), 64'(0));
      chk("rst_addr", 64'(om_addr), 64'(0));
      chk("rst_wdata", 64'(om_wdata), 64'(0));

      // single tile
      load_addrs(4);
      start_test();
      send_tile(0, 0);
      chk("single_valid_k", 64'(om_valid), 64'(0));
      @(negedge clk);
      chk("single_valid_k1", 64'(om_valid), 64'(1));
      wait_idle();
      chk("single_nwr", 64'(log_a.size()), 64'(4));
      chk("single_a0", 64'(log_a[0]), 64'(4));
      chk("single_d0", log_d[0], 64'h0000_0100_0200_0300);
      chk("single_a3", 64'(log_a[3]), 64'(7));
      chk("single_d3", log_d[3], 64'h0030_0130_0230_0330);
      chk("single_done", 64'(done_cnt), 64'(1));

      // skewed rows
      start_test();
      send_tile(0, 1);
      chk("skew_valid_k", 64'(om_valid), 64'(0));
      @(negedge clk);
      chk("skew_valid_k1", 64'(om_valid), 64'(1));
      wait_idle();
      chk("skew_nwr", 64'(log_a.size()), 64'(4));
      chk("skew_d0", log_d[0], 64'h0000_0100_0200_0300);
      chk("skew_d3", log_d[3], 64'h0030_0130_0230_0330);
      chk("skew_done", 64'(done_cnt), 64'(1));

      // backpressure mid-tile
      start_test();
      send_tile(1, 0);
      wait_log(1);
      om_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("bp_addr", 64'(om_addr), 64'(5));
         chk("bp_wdata", om_wdata, 64'h1010_1110_1210_1310);
      end
      om_ready = 1'b1;
      wait_idle();
      chk("bp_nwr", 64'(log_a.size()), 64'(4));
      for (int c = 0; c < 4; c++) chk("bp_order", 64'(log_a[c]), 64'(4 + c));
      chk("bp_done", 64'(done_cnt), 64'(1));

      // ping-pong with both banks full, third tile dropped
      start_test();
      om_ready = 1'b0;
      send_tile(2, 0);
      send_tile(3, 0);
      chk("pp_stall", 64'(in_stall), 64'(1));
      chk("pp_ovf_before", 64'(ovf), 64'(0));
      send_tile(4, 0);
      chk("pp_ovf", 64'(ovf), 64'(1));
      chk("pp_stall_held", 64'(in_stall), 64'(1));
      om_ready = 1'b1;
      wait_idle();
      chk("pp_nwr", 64'(log_a.size()), 64'(8));
      chk("pp_d0", log_d[0], 64'h2000_2100_2200_2300);
      chk("pp_d4", log_d[4], 64'h3000_3100_3200_3300);
      chk("pp_d7", log_d[7], 64'h3030_3130_3230_3330);
      chk("pp_done", 64'(done_cnt), 64'(2));

      // partial tiles
      start_test();
      col_total = CW'(2);
      send_tile(5, 0);
      wait_idle();
      chk("part_nwr", 64'(log_a.size()), 64'(2));
      chk("part_a1", 64'(log_a[1]), 64'(5));
      chk("part_d1", log_d[1], 64'h5010_5110_5210_5310);
      chk("part_done", 64'(done_cnt), 64'(1));
      start_test();
      col_total = CW'(0);
      send_tile(6, 0);
      wait_idle();
      chk("ct0_nwr", 64'(log_a.size()), 64'(4));
      chk("ct0_d3", log_d[3], 64'h6030_6130_6230_6330);

      // mid-drain clear
      start_test();
      col_total = CW'(4);
      send_tile(7, 0);
      wait_log(2);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk("clr_valid", 64'(om_valid), 64'(0));
      repeat (3) @(negedge clk);
      chk("clr_no_done", 64'(done_cnt), 64'(0));
      chk("clr_ovf_kept", 64'(ovf), 64'(1));
      chk("clr_stall", 64'(in_stall), 64'(0));
      load_addrs(8);
      start_test();
      send_tile(8, 0);
      wait_idle();
      chk("post_nwr", 64'(log_a.size()), 64'(4));
      chk("post_a0", 64'(log_a[0]), 64'(8));
      chk("post_d0", log_d[0], 64'h8000_8100_8200_8300);
      chk("post_done", 64'(done_cnt), 64'(1));

      // reset clears the sticky overflow
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst2_ovf", 64'(ovf), 64'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
